// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package chunked_seq_adder_pkg;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
      return (chunk == 0) ? 1 : width / chunk;
   endfunction

   // Chunk index counter needs at least one bit even when NCHUNK == 1.
   function automatic int unsigned idx_width(input int unsigned nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk_fa.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB for overflow detection.
module chunk_fa #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
      // Sum bit is a^b^carry_in, so the carry into the MSB falls out directly.
      c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
   end

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock through one slice, valid/ready on both sides.
// Optional subtract mode and signed-overflow output under `define CHUNKED_SEQ_ADDER_SUB_EN.
module chunked_seq_adder
   import chunked_seq_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int unsigned NCHUNK = num_chunks(WIDTH, CHUNK);
   localparam int unsigned IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0]    LastIdx   = IW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

   if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_cfg_check
      $error("chunked_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] accum_q, accum_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [31:0]      base;
   logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
   logic             sl_cout, msb_carry;

`ifdef CHUNKED_SEQ_ADDER_SUB_EN
   logic ovf_q, ovf_d;
   // a - b - cin == a + ~b + ~cin
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ^ cin;
   assign ovf     = ovf_q;
`else
   logic unused_msb_carry;
   assign b_eff            = b;
   assign cin_eff          = cin;
   assign unused_msb_carry = msb_carry;
`endif

   assign base = idx_q * CHUNK;
   assign sl_a = CHUNK'(a_q >> base);
   assign sl_b = CHUNK'(b_q >> base);

   chunk_fa #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a     (sl_a),
      .b     (sl_b),
      .cin   (carry_q),
      .sum   (sl_sum),
      .cout  (sl_cout),
      .c_msb (msb_carry)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      accum_d = accum_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_eff;
               carry_d = cin_eff;
               idx_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            accum_d = (accum_q & ~(ChunkMask << base)) | (WIDTH'(sl_sum) << base);
            carry_d = sl_cout;
            if (idx_q == LastIdx) begin
               sum_d   = accum_d;
               cout_d  = sl_cout;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
               ovf_d   = msb_carry ^ sl_cout;
`endif
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         accum_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         accum_q <= accum_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Randomised self-checking bench for chunked_seq_adder at WIDTH=8, CHUNK=2.
module tb_chunked_seq_adder;

   localparam int unsigned W = 8;
   localparam int unsigned C = 2;
   localparam int unsigned N = W / C;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] a, b;
   logic         cin;
   logic         out_valid, out_ready;
   logic [W-1:0] sum;
   logic         cout, busy;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
   logic         sub, ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   chunked_seq_adder #(
      .WIDTH (W),
      .CHUNK (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      .sub       (sub),
      .ovf       (ovf),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs();
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
   endtask

   // One full transaction: accept, wait for result, optionally stall in DONE, then consume.
   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                         input logic op_sub, input int stall, input bit disturb);
      logic [W-1:0] eb;
      logic         ec;
      logic [W:0]   full;
      logic         exp_ovf;
      int           lat;
      eb      = op_sub ? ~op_b : op_b;
      ec      = op_sub ? ~op_cin : op_cin;
      full    = {1'b0, op_a} + {1'b0, eb} + {{W{1'b0}}, ec};
      exp_ovf = (op_a[W-1] == eb[W-1]) && (full[W-1] != op_a[W-1]);

      check_eq("idle_in_ready", in_ready, 1);
      a   = op_a;
      b   = op_b;
      cin = op_cin;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      sub = op_sub;
`endif
      in_valid = 1'b1;
      tick();
      in_valid = disturb;
      if (disturb) scramble_inputs();
      check_eq("busy_in_ready", in_ready, 0);
      check_eq("busy_flag", busy, 1);

      lat = 0;
      while (!out_valid && lat < 4 * N + 8) begin
         tick();
         lat++;
         if (disturb) scramble_inputs();
      end
      check_eq("latency", lat, N);
      check_eq("sum", sum, full[W-1:0]);
      check_eq("cout", cout, full[W]);
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      check_eq("ovf", ovf, exp_ovf);
`endif

      repeat (stall) begin
         tick();
         if (disturb) scramble_inputs();
         check_eq("stall_out_valid", out_valid, 1);
         check_eq("stall_sum", sum, full[W-1:0]);
         check_eq("stall_cout", cout, full[W]);
         check_eq("stall_in_ready", in_ready, 0);
      end

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_eq("post_out_valid", out_valid, 0);
      check_eq("post_in_ready", in_ready, 1);
      check_eq("post_busy", busy, 0);
      check_eq("post_sum_hold", sum, full[W-1:0]);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      sub       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_sum", sum, 0);
      check_eq("rst_cout", cout, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      tick();
      check_eq("rel_in_ready", in_ready, 1);

      run_op(8'h03, 8'h05, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'hA7, 8'h3C, 1'b1, 1'b0, 5, 1'b1);
      run_op(8'h5A, 8'h69, 1'b0, 1'b0, 0, 1'b1);

      // Reset in the second BUSY cycle after a non-zero result is on the outputs.
      a        = 8'h12;
      b        = 8'h34;
      cin      = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_sum", sum, 0);
      check_eq("midrst_cout", cout, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_in_ready", in_ready, 1);
      tick();
      rst = 1'b0;
      tick();
      check_eq("after_rst_in_ready", in_ready, 1);
      run_op(8'h81, 8'h7F, 1'b0, 1'b0, 1, 1'b0);

`ifdef CHUNKED_SEQ_ADDER_SUB_EN
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom),
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
                1'($urandom),
`else
                1'b0,
`endif
                int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
